// File: rtl/mdu_unit.sv
// mdu_unit: multiply/divide unit with HI/LO registers.
// mult/multu/div/divu compute the full result at issue into pending
// registers, then hold busy for a fixed cycle count before writing HI/LO.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mdu_A,
  input  logic [31:0] mdu_B,
  input  logic [3:0]  MDUOp,
  input  logic        req,
  output logic        busy,
  output logic [31:0] mdu_out
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_t;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t      state;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic [3:0]  cnt;

  // Shared multiplier: operands extended by sign (mult) or zero (multu),
  // so the low 64 bits of the 64x64 product are the correct 32x32 result.
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  // Shared unsigned divider: signed div runs on magnitudes and the signs
  // are reapplied afterwards, which also makes 0x80000000 / -1 fall out
  // as 0x80000000 remainder 0 without any overflow special case.
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_den;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        is_mdu_op;
  logic        is_div_op;

  // Result datapath for the operation currently presented on MDUOp
  always_comb begin
    mul_signed = (MDUOp == OP_MULT);
    mul_a      = {{32{mul_signed & mdu_A[31]}}, mdu_A};
    mul_b      = {{32{mul_signed & mdu_B[31]}}, mdu_B};
    product    = mul_a * mul_b;

    div_signed = (MDUOp == OP_DIV);
    a_neg      = div_signed & mdu_A[31];
    b_neg      = div_signed & mdu_B[31];
    a_mag      = a_neg ? (32'd0 - mdu_A) : mdu_A;
    b_mag      = b_neg ? (32'd0 - mdu_B) : mdu_B;
    div_den    = (b_mag == '0) ? 32'd1 : b_mag;
    uq         = a_mag / div_den;
    ur         = a_mag % div_den;
    quot       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem        = a_neg ? (32'd0 - ur) : ur;

    is_mdu_op  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                 (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    is_div_op  = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);

    res_hi = product[63:32];
    res_lo = product[31:0];
    if (is_div_op) begin
      // Divide by zero re-latches the current HI/LO so completion is a no-op
      if (mdu_B == '0) begin
        res_hi = hi;
        res_lo = lo;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
  end

  // Issue, countdown, write-back and mthi/mtlo
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!req) begin
            if (is_mdu_op) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              cnt     <= is_div_op ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
              busy    <= 1'b1;
              state   <= S_BUSY;
            end else if (MDUOp == OP_MTHI) begin
              hi <= mdu_A;
            end else if (MDUOp == OP_MTLO) begin
              lo <= mdu_A;
            end
          end
        end
        S_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read port for mfhi/mflo; returns the committed HI/LO even while busy
  always_comb begin
    mdu_out = '0;
    if (MDUOp == OP_MFHI)      mdu_out = hi;
    else if (MDUOp == OP_MFLO) mdu_out = lo;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed table-driven bench for mdu_unit plus hand-written
// sequences for busy-time ignores, flushes and mid-operation reset.
module tb_mdu_unit;

  logic        clk;
  logic        reset;
  logic [31:0] mdu_A;
  logic [31:0] mdu_B;
  logic [3:0]  MDUOp;
  logic        req;
  logic        busy;
  logic [31:0] mdu_out;

  int checks;
  int failures;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .mdu_A   (mdu_A),
    .mdu_B   (mdu_B),
    .MDUOp   (MDUOp),
    .req     (req),
    .busy    (busy),
    .mdu_out (mdu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rq;
    logic [31:0] cyc;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reads HI and LO through the mfhi/mflo port between clock edges
  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    MDUOp = 4'd7;
    #1 h = mdu_out;
    MDUOp = 4'd8;
    #1 l = mdu_out;
    MDUOp = 4'd0;
  endtask

  // Presents an op for exactly one rising edge; returns at the next negedge
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rq);
    MDUOp = op;
    mdu_A = a;
    mdu_B = b;
    req   = rq;
    @(negedge clk);
    MDUOp = 4'd0;
    req   = 1'b0;
  endtask

  // Counts remaining busy cycles, bounded
  task automatic count_busy(input int start, output int n);
    n = start;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  logic [31:0] h;
  logic [31:0] l;
  int          n;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    mdu_A    = '0;
    mdu_B    = '0;
    MDUOp    = 4'd0;
    req      = 1'b0;

    //                op     a             b             rq    cyc  ehi           elo
    vecs[0]  = '{4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'h00000002, 1'b0, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000};
    vecs[4]  = '{4'd4, 32'h00000064, 32'h00000007, 1'b0, 10, 32'h00000002, 32'h0000000E};
    vecs[5]  = '{4'd1, 32'h00000007, 32'hFFFFFFFD, 1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[6]  = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{4'd6, 32'h00001234, 32'h00000000, 1'b0, 0,  32'h00000001, 32'h00001234};
    vecs[8]  = '{4'd5, 32'h00005678, 32'h00000000, 1'b0, 0,  32'h00005678, 32'h00001234};
    vecs[9]  = '{4'd4, 32'h00000009, 32'h00000000, 1'b0, 10, 32'h00005678, 32'h00001234};
    vecs[10] = '{4'd3, 32'hFFFFFFFF, 32'h00000000, 1'b0, 10, 32'h00005678, 32'h00001234};
    vecs[11] = '{4'd9, 32'h00000001, 32'h00000001, 1'b0, 0,  32'h00005678, 32'h00001234};
    vecs[12] = '{4'd1, 32'h00000003, 32'h00000004, 1'b1, 0,  32'h00005678, 32'h00001234};
    vecs[13] = '{4'd5, 32'h0000AAAA, 32'h00000000, 1'b1, 0,  32'h00005678, 32'h00001234};
    vecs[14] = '{4'd2, 32'h00010000, 32'h00010000, 1'b0, 5,  32'h00000001, 32'h00000000};
    vecs[15] = '{4'd7, 32'h00000002, 32'h00000003, 1'b0, 0,  32'h00000001, 32'h00000000};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    check("reset_hi", h, 32'd0);
    check("reset_lo", l, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rq);
      count_busy(0, n);
      check($sformatf("vec%0d_cycles", i), n, vecs[i].cyc);
      read_hilo(h, l);
      check($sformatf("vec%0d_hi", i), h, vecs[i].ehi);
      check($sformatf("vec%0d_lo", i), l, vecs[i].elo);
    end

    MDUOp = 4'd0;
    #1 check("out_none_zero", mdu_out, 32'd0);

    // Ops presented while busy are ignored; reads return old HI/LO
    issue(4'd6, 32'h00000077, 32'd0, 1'b0);
    issue(4'd5, 32'h00000066, 32'd0, 1'b0);
    issue(4'd1, 32'h00000003, 32'h00000004, 1'b0);
    check("ign_busy_c1", {31'd0, busy}, 32'd1);
    MDUOp = 4'd8;
    #1 check("ign_mflo_old", mdu_out, 32'h00000077);
    MDUOp = 4'd7;
    #1 check("ign_mfhi_old", mdu_out, 32'h00000066);
    issue(4'd5, 32'h0000AAAA, 32'd0, 1'b0);
    check("ign_busy_c2", {31'd0, busy}, 32'd1);
    // A restart attempt together with a flush must neither restart nor cancel
    issue(4'd1, 32'h00000005, 32'h00000005, 1'b1);
    count_busy(2, n);
    check("ign_cycles", n, 32'd5);
    read_hilo(h, l);
    check("ign_hi", h, 32'h00000000);
    check("ign_lo", l, 32'h0000000C);

    // Reset asserted on the 3rd busy cycle of a divide aborts it
    issue(4'd4, 32'h00000064, 32'h00000007, 1'b0);
    @(negedge clk);
    check("rst_busy_c2", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_busy_after", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    check("rst_hi_after", h, 32'd0);
    check("rst_lo_after", l, 32'd0);
    repeat (12) @(negedge clk);
    check("rst_busy_late", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    check("rst_hi_late", h, 32'd0);
    check("rst_lo_late", l, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
